int_mul_var_lat: RTL and testbench

- Parametrised, variable-latency iterative integer multiplier. It is the successor to the fixed-latency shift-add multiplier unit.
- Width is set by a parameter, and a per-request signed/unsigned mode bit selects the arithmetic.
- The result is the full double-width product.
- The block terminates early once the remaining multiplier bits are zero. It sits behind val/rdy request/response interfaces, as a drop-in for the fixed-latency unit.

---
 rtl/int_mul_var_lat.sv | 110 +++++++++++
 tb/tb_int_mul_var_lat.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_mul_var_lat.sv
// Variable-latency iterative shift-add multiplier behind val/rdy request and
// response interfaces. It stops early once the remaining multiplier bits are zero.
module int_mul_var_lat #(
   parameter int NBITS = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic [2*NBITS-1:0] req_msg,
   input  logic               req_signed,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic [2*NBITS-1:0] resp_msg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [2*NBITS-1:0] a_reg;
   logic [NBITS-1:0]   b_reg;
   logic [2*NBITS-1:0] result;
   logic               neg;

   logic [NBITS-1:0]   a_in;
   logic [NBITS-1:0]   b_in;
   logic [NBITS-1:0]   a_mag;
   logic [NBITS-1:0]   b_mag;
   logic [NBITS-1:0]   b_shift;
   logic [2*NBITS-1:0] sum;
   logic               req_go;
   logic               resp_go;

   assign a_in = req_msg[2*NBITS-1:NBITS];
   assign b_in = req_msg[NBITS-1:0];

   // Magnitudes fit in NBITS unsigned bits, including the most-negative value.
   assign a_mag = (req_signed && a_in[NBITS-1]) ? -a_in : a_in;
   assign b_mag = (req_signed && b_in[NBITS-1]) ? -b_in : b_in;

   assign b_shift = b_reg >> 1;
   assign sum     = result + (b_reg[0] ? a_reg : '0);

   always_comb begin
      req_rdy  = 1'bx;
      resp_val = 1'bx;
      case (state)
         IDLE: begin
            req_rdy  = 1'b1;
            resp_val = 1'b0;
         end
         CALC: begin
            req_rdy  = 1'b0;
            resp_val = 1'b0;
         end
         DONE: begin
            req_rdy  = 1'b0;
            resp_val = 1'b1;
         end
         default: begin
            req_rdy  = 1'bx;
            resp_val = 1'bx;
         end
      endcase
   end

   assign req_go   = req_val & req_rdy;
   assign resp_go  = resp_val & resp_rdy;
   assign resp_msg = result;

   // The sign is applied on the last CALC cycle, once no multiplier bits remain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         result <= '0;
         neg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_go) begin
                  a_reg  <= {{NBITS{1'b0}}, a_mag};
                  b_reg  <= b_mag;
                  result <= '0;
                  neg    <= req_signed & (a_in[NBITS-1] ^ b_in[NBITS-1]);
                  state  <= CALC;
               end
            end
            CALC: begin
               a_reg <= a_reg << 1;
               b_reg <= b_shift;
               if (b_shift == '0) begin
                  result <= neg ? -sum : sum;
                  state  <= DONE;
               end else begin
                  result <= sum;
               end
            end
            DONE: begin
               if (resp_go) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_mul_var_lat.sv
// Scoreboard bench for int_mul_var_lat: the driver queues the expected product and
// latency at each accepted request, and a monitor checks every response it sees.
module tb_int_mul_var_lat;

   localparam int N = 32;

   typedef struct {
      logic [2*N-1:0] prod;
      int             k;
      int             t;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           req_val = 1'b0;
   logic           req_rdy;
   logic [2*N-1:0] req_msg = '0;
   logic           req_signed = 1'b0;
   logic           resp_val;
   logic           resp_rdy;
   logic [2*N-1:0] resp_msg;

   logic           manual_rdy = 1'b1;
   logic           rand_rdy = 1'b0;
   logic           rnd_bit = 1'b1;

   int             checks = 0;
   int             failures = 0;
   int             cyc = 0;
   exp_t           exp_q[$];
   exp_t           cur;
   logic           holding = 1'b0;
   logic           expect_idle = 1'b0;

   int_mul_var_lat #(.NBITS(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_val    (req_val),
      .req_rdy    (req_rdy),
      .req_msg    (req_msg),
      .req_signed (req_signed),
      .resp_val   (resp_val),
      .resp_rdy   (resp_rdy),
      .resp_msg   (resp_msg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Random response back-pressure changes just after the rising edge.
   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   assign resp_rdy = rand_rdy ? rnd_bit : manual_rdy;

   task automatic check_output(input string name, input logic [2*N-1:0] act,
                               input logic [2*N-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, expv);
      end
   endtask

   function automatic int bit_len(input logic [N-1:0] v);
      int n;
      n = 1;
      for (int i = 0; i < N; i++) if (v[i]) n = i + 1;
      return n;
   endfunction

   function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic sgn);
      logic [2*N-1:0] ax, bx;
      ax = sgn ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
      bx = sgn ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
      return ax * bx;
   endfunction

   function automatic int ref_k(input logic [N-1:0] b, input logic sgn);
      logic [N-1:0] m;
      m = (sgn && b[N-1]) ? -b : b;
      return bit_len(m);
   endfunction

   task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn,
                                 input logic [2*N-1:0] expv, input int k, input int gap);
      exp_t e;
      bit   ok;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      req_val    = 1'b1;
      req_msg    = {a, b};
      req_signed = sgn;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (req_rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("[TB] FAIL req_accept_timeout: req_rdy never rose, required 1");
      end else begin
         e.prod = expv;
         e.k    = k;
         e.t    = cyc;
         exp_q.push_back(e);
         @(posedge clk);
      end
      #1;
      req_val = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !holding) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   // Monitor: pops on the first cycle of each response and checks it stays held.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         holding     = 1'b0;
         expect_idle = 1'b0;
      end else if (resp_val === 1'b1) begin
         if (!holding) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_resp: got 0x%016h with no request outstanding", resp_msg);
            end else begin
               cur = exp_q.pop_front();
               check_output("resp_msg", resp_msg, cur.prod);
               check_output("latency", 64'(cyc - cur.t), 64'(cur.k + 1));
            end
            holding = 1'b1;
         end else begin
            check_output("resp_hold", resp_msg, cur.prod);
         end
         check_output("req_rdy_in_done", {63'b0, req_rdy}, 64'd0);
         if (resp_rdy) begin
            holding     = 1'b0;
            expect_idle = 1'b1;
         end
      end else if (expect_idle) begin
         check_output("req_rdy_after_resp", {63'b0, req_rdy}, 64'd1);
         expect_idle = 1'b0;
      end
   end

   initial begin
      logic [N-1:0] ra, rb;
      logic         rs;
      bit           seen;

      #2;
      check_output("reset_req_rdy", {63'b0, req_rdy}, 64'd1);
      check_output("reset_resp_val", {63'b0, resp_val}, 64'd0);
      check_output("reset_resp_msg", resp_msg, 64'd0);
      #20;
      reset = 1'b1;

      apply_stimulus(32'h00000003, 32'h00000004, 1'b0, 64'h000000000000000C, 3, 0);
      wait_drain();
      apply_stimulus(32'hFFFFFFFD, 32'h00000004, 1'b1, 64'hFFFFFFFFFFFFFFF4, 3, 0);
      apply_stimulus(32'h00000005, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFB, 1, 0);
      apply_stimulus(32'h12345678, 32'h00000000, 1'b0, 64'h0000000000000000, 1, 0);
      apply_stimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 32, 0);
      apply_stimulus(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 32, 0);
      apply_stimulus(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 64'h000000000000002A, 3, 1);
      apply_stimulus(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 17, 0);
      apply_stimulus(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 32, 0);
      apply_stimulus(32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, 2, 2);
      apply_stimulus(32'h00000000, 32'hFFFFFFFB, 1'b1, 64'h0000000000000000, 3, 0);
      wait_drain();

      // Back-pressure: hold the response for five cycles before accepting it.
      manual_rdy = 1'b0;
      apply_stimulus(32'h00000006, 32'h00000007, 1'b0, 64'h000000000000002A, 3, 0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (resp_val === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL backpressure_timeout: resp_val never rose, required 1");
      end
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      manual_rdy = 1'b1;
      wait_drain();

      // Abort a long operation with an asynchronous reset between edges.
      apply_stimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 32, 0);
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_output("abort_req_rdy", {63'b0, req_rdy}, 64'd1);
      check_output("abort_resp_val", {63'b0, resp_val}, 64'd0);
      check_output("abort_resp_msg", resp_msg, 64'd0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      apply_stimulus(32'h00000007, 32'h00000006, 1'b0, 64'h000000000000002A, 3, 0);
      wait_drain();

      // Back-to-back signed/unsigned mix with random gaps and back-pressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? N'($urandom_range(0, 300)) : N'($urandom);
         rs = 1'($urandom_range(0, 1));
         apply_stimulus(ra, rb, rs, ref_prod(ra, rb, rs), ref_k(rb, rs), $urandom_range(0, 3));
      end
      wait_drain();
      rand_rdy = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
